div_seq_ctrl: RTL and testbench
===============================

// Module: div_seq_ctrl
// PURPOSE
// Sequencer for the RV32M divide path of the multi-cycle datapath. Accepts DIV/DIVU/REM/REMU
// from execute, folds signed operands to magnitudes and issues them to the unsigned pipelined
// divider. Counts pipeline latency, drives the datapath stall and div_cycles, then applies
// sign fix-up. Divide-by-zero and signed overflow complete without using the pipeline.
// PARAMETERS
// XLEN         32  operand/result width
// DIV_LATENCY   8  cycles from div_issue to valid pipe_quo/pipe_rem (>=1)
// CNT_W         4  width of latency counter / div_cycles (must hold DIV_LATENCY)
// PORTS
// clock_proc    in   1      processor clock, all state on rising edge
// rst           in   1      reset, synchronous, active-low
// start_valid   in   1      execute presents an M-ext op this cycle
// funct3        in   3      instruction funct3; only 3'b1xx (div/rem) accepted
// rs1_val       in   XLEN   dividend
// rs2_val       in   XLEN   divisor
// stall         out  1      hold PC/IR/regfile write; combinational
// div_cycles    out  CNT_W  remaining latency count (debug/trace)
// div_issue     out  1      one-cycle launch strobe to divider pipeline
// div_dividend  out  XLEN   unsigned dividend magnitude to pipeline (registered)
// div_divisor   out  XLEN   unsigned divisor magnitude to pipeline (registered)
// pipe_quo      in   XLEN   pipeline quotient
// pipe_rem      in   XLEN   pipeline remainder
// result_valid  out  1      one-cycle strobe: result is final, regfile may write
// result        out  XLEN   quotient (DIV/DIVU) or remainder (REM/REMU), registered
// BEHAVIOUR
// - Reset (rst==0 at edge): state=IDLE, counter=0, div_issue=0, result_valid=0, result=0,
//   div_dividend=div_divisor=0; stall forced 0 while rst==0.
// - States: IDLE, ISSUE, WAIT, DONE.
// - IDLE: accept iff start_valid && funct3[2]. Accept cycle A: stall=1 combinationally; latch
//   op, operands, neg_q = signed & (rs1[31]^rs2[31]) & divisor!=0, neg_r = signed & rs1[31].
//   start_valid with funct3[2]==0 is ignored, stall=0.
// - Special cases detected in A -> DONE at A+1 with no div_issue:
//   divisor==0: quo=all-ones, rem=rs1_val (all four ops).
//   DIV/REM and rs1==32'h80000000 and rs2==all-ones: quo=32'h80000000, rem=0.
// - Normal: A+1 ISSUE: div_issue=1, counter<=DIV_LATENCY, magnitudes on div_dividend/divisor
//   (abs for signed ops; |0x80000000| = 0x80000000 as unsigned).
//   A+2..A+1+DIV_LATENCY WAIT: counter decrements by 1 per cycle; when counter==1 capture
//   pipe_quo/pipe_rem, negate quo if neg_q, rem if neg_r, select by funct3[1] into result.
//   A+2+DIV_LATENCY DONE.
// - DONE: result_valid=1, stall=0, counter=0, -> IDLE. Total stall = DIV_LATENCY+2 cycles
//   (normal) or 1 cycle (special).
// - stall=1 in ISSUE and WAIT; start_valid outside IDLE is ignored (no queueing).
// - Back-to-back: op presented in the DONE cycle is not accepted; accepted next IDLE cycle.
// - Reset mid-operation: immediate return to IDLE; in-flight pipeline result discarded;
//   no result_valid produced.
// - div_cycles = counter; 0 in IDLE/ISSUE/DONE.
// - All arithmetic modulo 2^XLEN; negation is two's complement.
// STRUCTURE
// - Shared package rv32m_pkg: funct3 constants DIV=3'b100, DIVU=3'b101, REM=3'b110,
//   REMU=3'b111; state enum encoding; XLEN default.
// - One sub-module: div_sign_fix (combinational: operand abs on issue, result negate on
//   capture). FSM, counter and registers stay in div_seq_ctrl.
// - Bench divider model: pure delay line of DIV_LATENCY stages returning dividend/divisor,
//   dividend%divisor of the issued magnitudes.
// TESTING
// 1 DIVU 100/7, DIV_LATENCY=8: div_issue at A+1, stall high A..A+9, result_valid at A+10,
//   result=14; REMU same operands -> 2.
// 2 DIV -7/2 -> result 0xFFFFFFFD (-3); REM -7/2 -> 0xFFFFFFFF (-1); div_dividend=7 at issue.
// 3 DIV x/0 with x=0x12345678 -> result 0xFFFFFFFF at A+1, no div_issue, stall 1 cycle;
//   REMU x/0 -> 0x12345678.
// 4 DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same -> 0, both at A+1, no issue.
// 5 rst deasserted-to-0 at A+4 of a DIVU: next cycle IDLE, stall 0, no result_valid ever;
//   new DIVU 9/3 after release -> 3 with nominal timing.
// 6 start_valid with funct3=3'b000 (MUL) -> stall 0, no state change; start_valid held
//   during WAIT -> exactly one result_valid.

Source files
------------

// File: rtl/rv32m_pkg.sv
// Shared RV32M divide definitions: funct3 encodings, sequencer states.
package rv32m_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } div_state_t;

endpackage

// File: rtl/div_sign_fix.sv
// Signed/unsigned folding for the divide path: operand magnitudes
// on the way in, two's-complement negation of results on the way out.
module div_sign_fix
    import rv32m_pkg::*;
#(
    parameter int W = XLEN
) (
    input  logic         is_signed,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         neg_q,
    input  logic         neg_r,
    input  logic [W-1:0] quo,
    input  logic [W-1:0] rem,
    output logic [W-1:0] a_mag,
    output logic [W-1:0] b_mag,
    output logic [W-1:0] quo_fix,
    output logic [W-1:0] rem_fix
);

    // |most-negative| wraps to itself, which is the correct unsigned magnitude
    assign a_mag   = (is_signed && a[W-1]) ? (~a + 1'b1) : a;
    assign b_mag   = (is_signed && b[W-1]) ? (~b + 1'b1) : b;
    assign quo_fix = neg_q ? (~quo + 1'b1) : quo;
    assign rem_fix = neg_r ? (~rem + 1'b1) : rem;

endmodule

// File: rtl/div_seq_ctrl.sv
// RV32M divide sequencer: folds operands, launches the pipelined
// unsigned divider, counts its latency and fixes up result signs.
module div_seq_ctrl
    import rv32m_pkg::*;
#(
    parameter int XW          = XLEN,
    parameter int DIV_LATENCY = 8,
    parameter int CNT_W       = 4
) (
    input  logic             clock_proc,
    input  logic             rst,
    input  logic             start_valid,
    input  logic [2:0]       funct3,
    input  logic [XW-1:0]    rs1_val,
    input  logic [XW-1:0]    rs2_val,
    output logic             stall,
    output logic [CNT_W-1:0] div_cycles,
    output logic             div_issue,
    output logic [XW-1:0]    div_dividend,
    output logic [XW-1:0]    div_divisor,
    input  logic [XW-1:0]    pipe_quo,
    input  logic [XW-1:0]    pipe_rem,
    output logic             result_valid,
    output logic [XW-1:0]    result
);

    localparam logic [XW-1:0] MIN_NEG = {1'b1, {(XW-1){1'b0}}};

    div_state_t       state;
    logic [CNT_W-1:0] counter;
    logic             op_rem;
    logic             neg_q;
    logic             neg_r;

    logic          accept;
    logic          is_signed;
    logic          div_zero;
    logic          overflow;
    logic [XW-1:0] a_mag;
    logic [XW-1:0] b_mag;
    logic [XW-1:0] quo_fix;
    logic [XW-1:0] rem_fix;

    assign accept    = (state == S_IDLE) && start_valid && funct3[2];
    assign is_signed = ~funct3[0];
    assign div_zero  = (rs2_val == '0);
    assign overflow  = is_signed && (rs1_val == MIN_NEG) && (&rs2_val);

    assign stall = rst && (accept || state == S_ISSUE || state == S_WAIT);
    assign div_cycles = counter;

    div_sign_fix #(.W(XW)) u_fix (
        .is_signed (is_signed),
        .a         (rs1_val),
        .b         (rs2_val),
        .neg_q     (neg_q),
        .neg_r     (neg_r),
        .quo       (pipe_quo),
        .rem       (pipe_rem),
        .a_mag     (a_mag),
        .b_mag     (b_mag),
        .quo_fix   (quo_fix),
        .rem_fix   (rem_fix)
    );

    always_ff @(posedge clock_proc) begin
        if (!rst) begin
            state        <= S_IDLE;
            counter      <= '0;
            op_rem       <= 1'b0;
            neg_q        <= 1'b0;
            neg_r        <= 1'b0;
            div_issue    <= 1'b0;
            div_dividend <= '0;
            div_divisor  <= '0;
            result_valid <= 1'b0;
            result       <= '0;
        end else begin
            div_issue    <= 1'b0;
            result_valid <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_rem <= funct3[1];
                        neg_q  <= is_signed && (rs1_val[XW-1] ^ rs2_val[XW-1])
                                  && !div_zero;
                        neg_r  <= is_signed && rs1_val[XW-1];
                        // special cases bypass the pipeline entirely
                        if (div_zero) begin
                            result       <= funct3[1] ? rs1_val : '1;
                            result_valid <= 1'b1;
                            state        <= S_DONE;
                        end else if (overflow) begin
                            result       <= funct3[1] ? '0 : MIN_NEG;
                            result_valid <= 1'b1;
                            state        <= S_DONE;
                        end else begin
                            div_dividend <= a_mag;
                            div_divisor  <= b_mag;
                            div_issue    <= 1'b1;
                            state        <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    counter <= CNT_W'(DIV_LATENCY);
                    state   <= S_WAIT;
                end
                S_WAIT: begin
                    if (counter == CNT_W'(1)) begin
                        result       <= op_rem ? rem_fix : quo_fix;
                        result_valid <= 1'b1;
                        counter      <= '0;
                        state        <= S_DONE;
                    end else begin
                        counter <= counter - CNT_W'(1);
                    end
                end
                S_DONE: begin
                    counter <= '0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed bench for div_seq_ctrl with a delay-line divider model.
// Checks timing, sign fix-up, special cases, reset and ignored requests.
module tb_div_seq_ctrl;
    import rv32m_pkg::*;

    localparam int L = 8;

    logic        clock_proc = 1'b0;
    logic        rst = 1'b0;
    logic        start_valid = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] rs1_val = '0;
    logic [31:0] rs2_val = '0;
    logic        stall;
    logic [3:0]  div_cycles;
    logic        div_issue;
    logic [31:0] div_dividend;
    logic [31:0] div_divisor;
    logic [31:0] pipe_quo;
    logic [31:0] pipe_rem;
    logic        result_valid;
    logic [31:0] result;

    int n_checks = 0;
    int n_fail = 0;
    int rv_count = 0;
    int rv_snap;

    logic [31:0] sq [L];
    logic [31:0] sr [L];

    div_seq_ctrl #(.XW(32), .DIV_LATENCY(L), .CNT_W(4)) dut (
        .clock_proc   (clock_proc),
        .rst          (rst),
        .start_valid  (start_valid),
        .funct3       (funct3),
        .rs1_val      (rs1_val),
        .rs2_val      (rs2_val),
        .stall        (stall),
        .div_cycles   (div_cycles),
        .div_issue    (div_issue),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .pipe_quo     (pipe_quo),
        .pipe_rem     (pipe_rem),
        .result_valid (result_valid),
        .result       (result)
    );

    always #5 clock_proc = ~clock_proc;

    always @(posedge clock_proc) begin
        sq[0] <= (div_divisor != 0) ? div_dividend / div_divisor : '0;
        sr[0] <= (div_divisor != 0) ? div_dividend % div_divisor : '0;
        for (int i = 1; i < L; i++) begin
            sq[i] <= sq[i-1];
            sr[i] <= sr[i-1];
        end
    end
    assign pipe_quo = sq[L-1];
    assign pipe_rem = sr[L-1];

    always @(negedge clock_proc) if (result_valid) rv_count++;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock_proc);
        #1;
    endtask

    task automatic do_op(input string nm, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input logic [31:0] mag,
                         input bit special, input bit hold);
        start_valid = 1'b1;
        funct3 = f;
        rs1_val = a;
        rs2_val = b;
        #1;
        chk({nm, " accept stall"}, 32'(stall), 1);
        tick();
        if (!hold) start_valid = 1'b0;
        if (special) begin
            chk({nm, " sp valid"}, 32'(result_valid), 1);
            chk({nm, " sp result"}, result, exp_res);
            chk({nm, " sp no issue"}, 32'(div_issue), 0);
            chk({nm, " sp stall"}, 32'(stall), 0);
        end else begin
            chk({nm, " issue"}, 32'(div_issue), 1);
            chk({nm, " issue stall"}, 32'(stall), 1);
            chk({nm, " issue cnt"}, 32'(div_cycles), 0);
            chk({nm, " dividend"}, div_dividend, mag);
            for (int k = 0; k < L; k++) begin
                tick();
                chk({nm, " wait stall"}, 32'(stall), 1);
                chk({nm, " wait cnt"}, 32'(div_cycles), 32'(L - k));
                chk({nm, " wait no valid"}, 32'(result_valid), 0);
            end
            tick();
            chk({nm, " done valid"}, 32'(result_valid), 1);
            chk({nm, " result"}, result, exp_res);
            chk({nm, " done stall"}, 32'(stall), 0);
            chk({nm, " done cnt"}, 32'(div_cycles), 0);
        end
        start_valid = 1'b0;
        tick();
        chk({nm, " idle valid"}, 32'(result_valid), 0);
        chk({nm, " idle stall"}, 32'(stall), 0);
    endtask

    initial begin
        #1;
        chk("rst stall", 32'(stall), 0);
        tick();
        tick();
        chk("rst result", result, 0);
        chk("rst valid", 32'(result_valid), 0);
        chk("rst issue", 32'(div_issue), 0);
        chk("rst cnt", 32'(div_cycles), 0);
        chk("rst dividend", div_dividend, 0);
        chk("rst divisor", div_divisor, 0);
        rst = 1'b1;
        tick();

        do_op("divu", F3_DIVU, 100, 7, 14, 100, 0, 0);
        do_op("remu", F3_REMU, 100, 7, 2, 100, 0, 0);
        do_op("div neg", F3_DIV, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFD, 7, 0, 0);
        do_op("rem neg", F3_REM, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFF, 7, 0, 0);
        do_op("div negb", F3_DIV, 7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 7, 0, 0);
        do_op("rem negb", F3_REM, 7, 32'hFFFF_FFFE, 1, 7, 0, 0);
        do_op("div z", F3_DIV, 32'h1234_5678, 0, 32'hFFFF_FFFF, 0, 1, 0);
        do_op("remu z", F3_REMU, 32'h1234_5678, 0, 32'h1234_5678, 0, 1, 0);
        do_op("div ovf", F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
              32'h8000_0000, 0, 1, 0);
        do_op("rem ovf", F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 1, 0);

        // reset in the middle of an operation
        rv_snap = rv_count;
        start_valid = 1'b1;
        funct3 = F3_DIVU;
        rs1_val = 50;
        rs2_val = 5;
        tick();
        start_valid = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("mid rst stall", 32'(stall), 0);
        tick();
        rst = 1'b1;
        #1;
        chk("post rst stall", 32'(stall), 0);
        chk("post rst cnt", 32'(div_cycles), 0);
        for (int i = 0; i < 12; i++) tick();
        chk("post rst no valid", 32'(rv_count), 32'(rv_snap));
        do_op("divu after rst", F3_DIVU, 9, 3, 3, 9, 0, 0);

        // non-divide op ignored
        rv_snap = rv_count;
        start_valid = 1'b1;
        funct3 = 3'b000;
        rs1_val = 6;
        rs2_val = 2;
        #1;
        chk("mul stall", 32'(stall), 0);
        tick();
        chk("mul no issue", 32'(div_issue), 0);
        chk("mul cnt", 32'(div_cycles), 0);
        start_valid = 1'b0;
        tick();
        chk("mul no valid", 32'(rv_count), 32'(rv_snap));

        // start_valid held through the whole operation
        rv_snap = rv_count;
        do_op("hold", F3_DIVU, 45, 6, 7, 45, 0, 1);
        for (int i = 0; i < 3; i++) tick();
        chk("hold one valid", 32'(rv_count), 32'(rv_snap + 1));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
